dac_fifo_rd_sched: RTL and testbench



---
 rtl/dac_fifo_rd_sched_pkg.sv | 17 +
 rtl/dac_fifo_rd_sched_if.sv | 22 ++
 rtl/dac_fifo_rd_sched_rd_phase_cnt.sv | 51 +++++
 rtl/dac_fifo_rd_sched.sv | 105 ++++++++++
 tb/tb_dac_fifo_rd_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_fifo_rd_sched_pkg.sv
// Shared types and helpers for the DAC read-side scheduler.
// Combinational only; no latency, no backpressure.
package dac_sched_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int unsigned MIN_RATIO = 1;

    // A configured ratio of 0 would stall the phase counter, so clamp it to 1.
    function automatic int unsigned eff_ratio(input int unsigned cfg);
        return (cfg < MIN_RATIO) ? MIN_RATIO : cfg;
    endfunction

endpackage

// File: rtl/dac_fifo_rd_sched_if.sv
// FIFO read port and DAC sample port seen by the read scheduler.
// master = scheduler, slave = FIFO/DAC side; no handshake beyond the read strobe.
interface dac_fifo_rd_sched_if #(
    parameter int DATA_WIDTH = 14
);
    logic                         fifo_rd_en;
    logic signed [DATA_WIDTH-1:0] fifo_dout;
    logic                         fifo_above_half;
    logic                         fifo_empty;
    logic signed [DATA_WIDTH-1:0] dac_data;
    logic                         dac_valid;

    modport master (
        output fifo_rd_en, dac_data, dac_valid,
        input  fifo_dout, fifo_above_half, fifo_empty
    );

    modport slave (
        input  fifo_rd_en, dac_data, dac_valid,
        output fifo_dout, fifo_above_half, fifo_empty
    );
endinterface

// File: rtl/dac_fifo_rd_sched_rd_phase_cnt.sv
// Read-period phase counter; ratio is latched at reset release, on clear and at each wrap.
// phase_zero is a decode of the phase register; no backpressure.
module rd_phase_cnt
    import dac_sched_pkg::*;
#(
    parameter int RATIO_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATIO_W-1:0] ratio_cfg,
    input  logic               en,
    input  logic               clear,
    output logic               phase_zero
);

    logic [RATIO_W-1:0] phase_q;
    logic [RATIO_W-1:0] ratio_q;
    logic               loaded_q;
    logic [RATIO_W-1:0] new_ratio;
    logic               wrap;

    assign new_ratio  = RATIO_W'(eff_ratio(32'(ratio_cfg)));
    assign wrap       = (phase_q == ratio_q - 1'b1);
    assign phase_zero = (phase_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            ratio_q  <= RATIO_W'(MIN_RATIO);
            loaded_q <= 1'b0;
        end else begin
            if (!loaded_q) begin
                ratio_q  <= new_ratio;
                loaded_q <= 1'b1;
            end
            // Ratio changes only take effect on a period boundary.
            if (clear) begin
                phase_q <= '0;
                ratio_q <= new_ratio;
            end else if (en) begin
                if (wrap) begin
                    phase_q <= '0;
                    ratio_q <= new_ratio;
                end else begin
                    phase_q <= phase_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dac_fifo_rd_sched.sv
// FIFO-to-DAC read scheduler: prefill to above-half, one read per ratio clocks, refill on underrun.
// Read strobe registered; sample reaches dac_data one clock after FIFO data; DAC side cannot stall.
// Option DAC_ZERO_ON_UNDERRUN_EN: drive a zero sample (with dac_valid) after each underrun.
module dac_fifo_rd_sched
    import dac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int RATIO_W    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RATIO_W-1:0]        ratio_cfg,
    dac_fifo_rd_sched_if.master       bus,
    output logic                      streaming,
    output logic                      underrun,
    output logic [CNT_W-1:0]          underrun_cnt
);

    sched_state_t state_q;
    logic         phase_zero;
    logic         enter_run;
    logic         rd_pend_q;

    // Empty dominates above_half so a glitching flag pair cannot start a stream.
    assign enter_run = (state_q == FILL) && bus.fifo_above_half && !bus.fifo_empty;

    rd_phase_cnt #(
        .RATIO_W (RATIO_W)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .ratio_cfg  (ratio_cfg),
        .en         (state_q == RUN),
        .clear      (enter_run),
        .phase_zero (phase_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            streaming      <= 1'b0;
            underrun       <= 1'b0;
            underrun_cnt   <= '0;
            bus.fifo_rd_en <= 1'b0;
        end else begin
            underrun       <= 1'b0;
            bus.fifo_rd_en <= 1'b0;
            case (state_q)
                FILL: begin
                    if (enter_run) begin
                        state_q   <= RUN;
                        streaming <= 1'b1;
                    end
                end
                RUN: begin
                    if (phase_zero) begin
                        if (bus.fifo_empty) begin
                            state_q   <= FILL;
                            streaming <= 1'b0;
                            underrun  <= 1'b1;
                            if (underrun_cnt != '1) begin
                                underrun_cnt <= underrun_cnt + 1'b1;
                            end
                        end else begin
                            bus.fifo_rd_en <= 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef DAC_ZERO_ON_UNDERRUN_EN
    logic zero_arm_q;
`endif

    // rd_pend_q marks the clock in which the FIFO presents the data for last cycle's strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q     <= 1'b0;
            bus.dac_data  <= '0;
            bus.dac_valid <= 1'b0;
`ifdef DAC_ZERO_ON_UNDERRUN_EN
            zero_arm_q    <= 1'b0;
`endif
        end else begin
            rd_pend_q     <= bus.fifo_rd_en;
            bus.dac_valid <= rd_pend_q;
            if (rd_pend_q) begin
                bus.dac_data <= bus.fifo_dout;
            end
`ifdef DAC_ZERO_ON_UNDERRUN_EN
            // Lands one clock after any in-flight sample, so it never collides with a capture.
            zero_arm_q <= underrun;
            if (zero_arm_q) begin
                bus.dac_data  <= '0;
                bus.dac_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dac_fifo_rd_sched.sv
// Directed bench for dac_fifo_rd_sched: stimulus queues expected DAC samples,
// a negedge monitor models the FIFO read latency and scores every dac_valid.
module tb_dac_fifo_rd_sched;

    localparam int DW = 14;
    localparam int RW = 4;
    localparam int CW = 4;

    typedef struct {
        logic signed [DW-1:0] data;
        bit                   from_read;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] ratio_cfg = 4'd4;
    logic          streaming;
    logic          underrun;
    logic [CW-1:0] underrun_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t                 exp_q[$];
    logic signed [DW-1:0] fifo_q[$];
    int                   rd_q[$];
    int                   rd_log[$];

    dac_fifo_rd_sched_if #(.DATA_WIDTH(DW)) bus ();

    dac_fifo_rd_sched #(
        .DATA_WIDTH (DW),
        .RATIO_W    (RW),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ratio_cfg    (ratio_cfg),
        .bus          (bus),
        .streaming    (streaming),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model + scoreboard monitor. Data for a strobe seen in cycle c is driven
    // at the negedge of c+1, i.e. stable for the DUT's capture edge at the end of c+1.
    logic                 pend;
    logic signed [DW-1:0] pend_val;
    initial pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rd_q.delete();
            pend = 1'b0;
            bus.fifo_dout = '0;
        end else begin
            if (pend) bus.fifo_dout = pend_val;
            pend = 1'b0;
            if (bus.dac_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dac_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dac_data", bus.dac_data, e.data);
                    if (e.from_read) begin
                        if (rd_q.size() == 0) check("valid_without_read", 1, 0);
                        else check("rd_to_valid_latency", cyc - rd_q.pop_front(), 2);
                    end
                end
            end
            check("rd_while_empty", bus.fifo_rd_en && bus.fifo_empty, 0);
            if (bus.fifo_rd_en) begin
                rd_q.push_back(cyc);
                rd_log.push_back(cyc);
                pend = 1'b1;
                pend_val = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [RW-1:0] r);
        ratio_cfg           = r;
        bus.fifo_above_half = 1'b0;
        bus.fifo_empty      = 1'b0;
        rst                 = 1'b1;
        step(2);
        rst = 1'b0;
        rd_log.delete();
        fifo_q.delete();
    endtask

    task automatic push_sample(input logic signed [DW-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back('{data: v, from_read: 1'b1});
    endtask

    task automatic push_zero();
`ifdef DAC_ZERO_ON_UNDERRUN_EN
        exp_q.push_back('{data: '0, from_read: 1'b0});
`endif
    endtask

    initial begin
        int c0;
        int c1;
        int offs4[6];
        int offs1[3];
        logic signed [DW-1:0] last_expect;

        bus.fifo_above_half = 1'b0;
        bus.fifo_empty      = 1'b0;

        // Reset state
        step(2);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_dac_data", bus.dac_data, 0);
        check("rst_dac_valid", bus.dac_valid, 0);
        check("rst_streaming", streaming, 0);
        check("rst_underrun", underrun, 0);
        check("rst_underrun_cnt", underrun_cnt, 0);

        // Prefill with ratio 4; empty+above_half together must not start the stream
        do_reset(4'd4);
        step(20);
        check("fill_no_reads", rd_log.size(), 0);
        check("fill_streaming", streaming, 0);
        bus.fifo_above_half = 1'b1;
        bus.fifo_empty      = 1'b1;
        step(3);
        check("empty_dominates_streaming", streaming, 0);
        check("empty_dominates_reads", rd_log.size(), 0);
        push_sample(14'sd11);
        push_sample(14'sd22);
        push_sample(14'sd33);
        bus.fifo_empty = 1'b0;
        c0 = cyc;
        step(1);
        check("prefill_streaming", streaming, 1);
        step(11);
        // FSM enters RUN on the next edge, first strobe one clock later, then every 4.
        offs1 = '{2, 6, 10};
        check("prefill_read_count", rd_log.size(), 3);
        for (int i = 0; i < 3 && i < rd_log.size(); i++)
            check("prefill_read_slot", rd_log[i] - c0, offs1[i]);
        check("prefill_scoreboard_drained", exp_q.size(), 0);

        // Data path, ratio 1, full signed range; underrun after the 4th strobe
        do_reset(4'd1);
        push_sample(14'sd100);
        push_sample(-14'sd200);
        push_sample(14'sd8191);
        push_sample(-14'sd8192);
        bus.fifo_above_half = 1'b1;
        c0 = cyc;
        step(5);
        bus.fifo_empty      = 1'b1;
        bus.fifo_above_half = 1'b0;
        push_zero();
        step(4);
        check("data_read_count", rd_log.size(), 4);
        check("data_underrun_cnt", underrun_cnt, 1);
        check("data_streaming_off", streaming, 0);
`ifdef DAC_ZERO_ON_UNDERRUN_EN
        last_expect = '0;
`else
        last_expect = -14'sd8192;
`endif
        check("dac_data_after_underrun", bus.dac_data, last_expect);
        check("data_scoreboard_drained", exp_q.size(), 0);

        // Underrun at a phase-0 clock with ratio 2, then refill
        do_reset(4'd2);
        push_sample(14'sd7);
        push_sample(14'sd8);
        bus.fifo_above_half = 1'b1;
        c0 = cyc;
        step(5);
        bus.fifo_empty      = 1'b1;
        bus.fifo_above_half = 1'b0;
        push_zero();
        step(1);
        check("ur_pulse", underrun, 1);
        check("ur_streaming", streaming, 0);
        check("ur_cnt", underrun_cnt, 1);
        check("ur_no_read", bus.fifo_rd_en, 0);
        step(1);
        check("ur_single_pulse", underrun, 0);
        check("ur_read_count", rd_log.size(), 2);
        step(1);
        push_sample(14'sd9);
        bus.fifo_empty      = 1'b0;
        bus.fifo_above_half = 1'b1;
        c1 = cyc;
        step(1);
        check("refill_streaming", streaming, 1);
        step(3);
        check("refill_read_slot", rd_log[2] - c1, 2);
        check("refill_cnt_hold", underrun_cnt, 1);
        check("refill_scoreboard_drained", exp_q.size(), 0);

        // Ratio 3 -> 5 at phase 1, later 0 (treated as 1)
        do_reset(4'd3);
        for (int i = 1; i <= 6; i++) push_sample(DW'(i * 1000 - 4000));
        bus.fifo_above_half = 1'b1;
        c0 = cyc;
        step(2);
        ratio_cfg = 4'd5;
        step(8);
        ratio_cfg = 4'd0;
        step(7);
        bus.fifo_empty      = 1'b1;
        bus.fifo_above_half = 1'b0;
        push_zero();
        step(4);
        offs4 = '{2, 5, 10, 15, 16, 17};
        check("ratio_read_count", rd_log.size(), 6);
        for (int i = 0; i < 6 && i < rd_log.size(); i++)
            check("ratio_read_slot", rd_log[i] - c0, offs4[i]);
        check("ratio_scoreboard_drained", exp_q.size(), 0);

        // Counter saturation: 2^CW + 3 underruns
        do_reset(4'd1);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            bus.fifo_above_half = 1'b1;
            bus.fifo_empty      = 1'b0;
            step(1);
            bus.fifo_above_half = 1'b0;
            bus.fifo_empty      = 1'b1;
            push_zero();
            step(4);
            check("sat_cnt", underrun_cnt, (i + 1 > 15) ? 15 : i + 1);
        end
        check("sat_scoreboard_drained", exp_q.size(), 0);

        // Async reset while a read is in flight: pending data must be dropped
        do_reset(4'd1);
        push_sample(14'sd55);
        push_sample(14'sd66);
        push_sample(14'sd77);
        bus.fifo_above_half = 1'b1;
        step(4);
        check("inflight_rd_en", bus.fifo_rd_en, 1);
        rst = 1'b1;
        #1;
        check("arst_dac_data", bus.dac_data, 0);
        check("arst_dac_valid", bus.dac_valid, 0);
        check("arst_streaming", streaming, 0);
        check("arst_rd_en", bus.fifo_rd_en, 0);
        bus.fifo_above_half = 1'b0;
        step(2);
        rst = 1'b0;
        step(5);
        check("post_arst_streaming", streaming, 0);
        check("post_arst_dac_data", bus.dac_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
